// File: rtl/instruction_decoder_lj_pkg.sv
// Shared constants, state encoding and decoded-field bundle for the long-jump
// instruction decoder.
package instruction_decoder_lj_pkg;

    // Opcode prefixes; each is matched against the top bits of the word.
    localparam logic       OP_LOAD = 1'b0;
    localparam logic [1:0] OP_MOV  = 2'b10;
    localparam logic [2:0] OP_ALU  = 3'b110;
    localparam logic [3:0] OP_JMP  = 4'b1110;
    localparam logic [3:0] OP_JNZ  = 4'b1111;

    // "jmp 0" introduces a two-word long jump.
    localparam logic [7:0] LONG_JMP_WORD = 8'hE0;

    // Field positions within the instruction word.
    localparam int unsigned LOAD_DST_LSB = 4;
    localparam int unsigned MOV_DST_LSB  = 3;
    localparam int unsigned SRC_LSB      = 0;
    localparam int unsigned ALU_X_BIT    = 4;
    localparam int unsigned ALU_Y_BIT    = 3;
    localparam int unsigned FUNC_LSB     = 0;
    localparam int unsigned NIBBLE_LSB   = 0;

    typedef enum logic [0:0] {
        StNormal,
        StLongTgt
    } state_e;

    typedef struct packed {
        logic       load_en;
        logic       mov_en;
        logic       alu_en;
        logic       jmp;
        logic       jmp_nz;
        logic [3:0] jmp_addr;
        logic [2:0] dst_sel;
        logic [2:0] src_sel;
        logic [2:0] alu_func;
        logic       x_sel;
        logic       y_sel;
        logic [3:0] imm;
    } decoded_t;

endpackage

// File: rtl/instruction_decoder_lj_if.sv
// Decoder-facing bus: instruction word in, sequencer controls and datapath
// strobes out.
interface instruction_decoder_lj_if #(
    parameter int unsigned CNT_W = 16
);
    logic [7:0]       pm_data;
    logic             jmp;
    logic             jmp_nz;
    logic [3:0]       jmp_addr;
    logic [7:0]       jump_to;
    logic             load_en;
    logic             mov_en;
    logic             alu_en;
    logic [2:0]       dst_sel;
    logic [2:0]       src_sel;
    logic [2:0]       alu_func;
    logic             x_sel;
    logic             y_sel;
    logic [3:0]       imm;
    logic             long_pending;
    logic [7:0]       ir;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  pm_data,
        output jmp, jmp_nz, jmp_addr, jump_to, load_en, mov_en, alu_en,
        output dst_sel, src_sel, alu_func, x_sel, y_sel, imm, long_pending,
        output ir, instr_count
    );

    modport slave (
        output pm_data,
        input  jmp, jmp_nz, jmp_addr, jump_to, load_en, mov_en, alu_en,
        input  dst_sel, src_sel, alu_func, x_sel, y_sel, imm, long_pending,
        input  ir, instr_count
    );
endinterface

// File: rtl/instruction_decoder_lj_field_decode.sv
// Purely combinational opcode/field split of one instruction word; unused
// fields stay zero.
module instr_field_decode
    import instruction_decoder_lj_pkg::*;
(
    input  logic [7:0] word,
    output decoded_t   dec
);

    always_comb begin
        dec = '0;
        if (word[7] == OP_LOAD) begin
            dec.load_en = 1'b1;
            dec.dst_sel = word[LOAD_DST_LSB +: 3];
            dec.imm     = word[NIBBLE_LSB +: 4];
        end else if (word[7:6] == OP_MOV) begin
            dec.mov_en  = 1'b1;
            dec.dst_sel = word[MOV_DST_LSB +: 3];
            dec.src_sel = word[SRC_LSB +: 3];
        end else if (word[7:5] == OP_ALU) begin
            dec.alu_en   = 1'b1;
            dec.x_sel    = word[ALU_X_BIT];
            dec.y_sel    = word[ALU_Y_BIT];
            dec.alu_func = word[FUNC_LSB +: 3];
        end else if (word[7:4] == OP_JMP) begin
            dec.jmp      = 1'b1;
            dec.jmp_addr = word[NIBBLE_LSB +: 4];
        end else begin
            dec.jmp_nz   = 1'b1;
            dec.jmp_addr = word[NIBBLE_LSB +: 4];
        end
    end

endmodule

// File: rtl/instruction_decoder_lj.sv
// Instruction decoder with two-word long jump; state mirrors the sequencer's
// jump_flag so the literal word is forwarded as jump_to instead of executed.
module instruction_decoder_lj
    import instruction_decoder_lj_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     sync_reset,
    instruction_decoder_lj_if.master bus
);

    decoded_t         dec;
    state_e           state_q, state_d;
    logic [7:0]       ir_q;
    logic [CNT_W-1:0] count_q;

    instr_field_decode u_field_decode (
        .word (bus.pm_data),
        .dec  (dec)
    );

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= StNormal;
            ir_q    <= 8'h00;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= bus.pm_data;
            if (state_q == StNormal) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.load_en      = 1'b0;
        bus.mov_en       = 1'b0;
        bus.alu_en       = 1'b0;
        bus.jmp          = 1'b0;
        bus.jmp_nz       = 1'b0;
        bus.jmp_addr     = 4'h0;
        bus.dst_sel      = 3'h0;
        bus.src_sel      = 3'h0;
        bus.alu_func     = 3'h0;
        bus.x_sel        = 1'b0;
        bus.y_sel        = 1'b0;
        bus.imm          = 4'h0;
        bus.jump_to      = 8'h00;
        bus.long_pending = 1'b0;
        unique case (state_q)
            StNormal: begin
                if (bus.pm_data == LONG_JMP_WORD) begin
                    state_d = StLongTgt;
                end
                if (!sync_reset) begin
                    bus.load_en  = dec.load_en;
                    bus.mov_en   = dec.mov_en;
                    bus.alu_en   = dec.alu_en;
                    bus.jmp      = dec.jmp;
                    bus.jmp_nz   = dec.jmp_nz;
                    bus.jmp_addr = dec.jmp_addr;
                    bus.dst_sel  = dec.dst_sel;
                    bus.src_sel  = dec.src_sel;
                    bus.alu_func = dec.alu_func;
                    bus.x_sel    = dec.x_sel;
                    bus.y_sel    = dec.y_sel;
                    bus.imm      = dec.imm;
                end
            end
            StLongTgt: begin
                // Literal word: forwarded as the target, never decoded.
                state_d = StNormal;
                if (!sync_reset) begin
                    bus.long_pending = 1'b1;
                    bus.jump_to      = bus.pm_data;
                end
            end
            default: state_d = StNormal;
        endcase
    end

    assign bus.ir          = ir_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_instruction_decoder_lj.sv
// Directed bench for instruction_decoder_lj: drives words on the falling edge,
// checks decode before the rising edge and registered state just after it.
module tb_instruction_decoder_lj;

    logic clk;
    logic sync_reset;
    int   n_total;
    int   n_pass;

    instruction_decoder_lj_if #(.CNT_W(16)) bus ();

    instruction_decoder_lj #(.CNT_W(16)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // strb = {load_en, mov_en, alu_en, jmp, jmp_nz, long_pending}
    task automatic check_outs(input string tag, input logic [5:0] strb, input logic [3:0] jaddr,
                              input logic [7:0] jto, input logic [2:0] dst,
                              input logic [2:0] src, input logic [2:0] func,
                              input logic [1:0] xy, input logic [3:0] imm);
        check({tag, ".strb"}, {26'd0, bus.load_en, bus.mov_en, bus.alu_en, bus.jmp, bus.jmp_nz,
                               bus.long_pending}, {26'd0, strb});
        check({tag, ".jmp_addr"}, {28'd0, bus.jmp_addr}, {28'd0, jaddr});
        check({tag, ".jump_to"}, {24'd0, bus.jump_to}, {24'd0, jto});
        check({tag, ".dst"}, {29'd0, bus.dst_sel}, {29'd0, dst});
        check({tag, ".src"}, {29'd0, bus.src_sel}, {29'd0, src});
        check({tag, ".func"}, {29'd0, bus.alu_func}, {29'd0, func});
        check({tag, ".xy"}, {30'd0, bus.x_sel, bus.y_sel}, {30'd0, xy});
        check({tag, ".imm"}, {28'd0, bus.imm}, {28'd0, imm});
    endtask

    // Apply one word for one cycle; check decode, then ir/count after the edge.
    task automatic step(input string tag, input logic rst, input logic [7:0] word,
                        input logic [5:0] strb, input logic [3:0] jaddr, input logic [7:0] jto,
                        input logic [2:0] dst, input logic [2:0] src, input logic [2:0] func,
                        input logic [1:0] xy, input logic [3:0] imm,
                        input logic [7:0] exp_ir, input logic [15:0] exp_cnt);
        @(negedge clk);
        sync_reset  = rst;
        bus.pm_data = word;
        #4;
        check_outs(tag, strb, jaddr, jto, dst, src, func, xy, imm);
        @(posedge clk);
        #1;
        check({tag, ".ir"}, {24'd0, bus.ir}, {24'd0, exp_ir});
        check({tag, ".count"}, {16'd0, bus.instr_count}, {16'd0, exp_cnt});
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        sync_reset  = 1'b1;
        bus.pm_data = 8'h35;
        // tag, rst, word, strb, jaddr, jump_to, dst, src, func, xy, imm, ir, count
        step("rst0", 1'b1, 8'h35, 6'b000000, 4'h0, 8'h00, 3'd0, 3'd0, 3'd0, 2'b00, 4'h0, 8'h00, 16'd0);
        step("rst1", 1'b1, 8'hE0, 6'b000000, 4'h0, 8'h00, 3'd0, 3'd0, 3'd0, 2'b00, 4'h0, 8'h00, 16'd0);
        step("ld35", 1'b0, 8'h35, 6'b100000, 4'h0, 8'h00, 3'd3, 3'd0, 3'd0, 2'b00, 4'h5, 8'h35, 16'd1);
        step("jmpE7", 1'b0, 8'hE7, 6'b000100, 4'h7, 8'h00, 3'd0, 3'd0, 3'd0, 2'b00, 4'h0, 8'hE7, 16'd2);
        step("ld7F", 1'b0, 8'h7F, 6'b100000, 4'h0, 8'h00, 3'd7, 3'd0, 3'd0, 2'b00, 4'hF, 8'h7F, 16'd3);
        step("ljE0a", 1'b0, 8'hE0, 6'b000100, 4'h0, 8'h00, 3'd0, 3'd0, 3'd0, 2'b00, 4'h0, 8'hE0, 16'd4);
        step("lit9C", 1'b0, 8'h9C, 6'b000001, 4'h0, 8'h9C, 3'd0, 3'd0, 3'd0, 2'b00, 4'h0, 8'h9C, 16'd4);
        step("ljE0b", 1'b0, 8'hE0, 6'b000100, 4'h0, 8'h00, 3'd0, 3'd0, 3'd0, 2'b00, 4'h0, 8'hE0, 16'd5);
        step("litE0", 1'b0, 8'hE0, 6'b000001, 4'h0, 8'hE0, 3'd0, 3'd0, 3'd0, 2'b00, 4'h0, 8'hE0, 16'd5);
        step("ld12", 1'b0, 8'h12, 6'b100000, 4'h0, 8'h00, 3'd1, 3'd0, 3'd0, 2'b00, 4'h2, 8'h12, 16'd6);
        step("jnzF0", 1'b0, 8'hF0, 6'b000010, 4'h0, 8'h00, 3'd0, 3'd0, 3'd0, 2'b00, 4'h0, 8'hF0, 16'd7);
        step("mov9C", 1'b0, 8'h9C, 6'b010000, 4'h0, 8'h00, 3'd3, 3'd4, 3'd0, 2'b00, 4'h0, 8'h9C, 16'd8);
        step("aluD5", 1'b0, 8'hD5, 6'b001000, 4'h0, 8'h00, 3'd0, 3'd0, 3'd5, 2'b10, 4'h0, 8'hD5, 16'd9);
        step("aluCB", 1'b0, 8'hCB, 6'b001000, 4'h0, 8'h00, 3'd0, 3'd0, 3'd3, 2'b01, 4'h0, 8'hCB, 16'd10);
        step("jnzFA", 1'b0, 8'hFA, 6'b000010, 4'hA, 8'h00, 3'd0, 3'd0, 3'd0, 2'b00, 4'h0, 8'hFA, 16'd11);
        step("ljE0c", 1'b0, 8'hE0, 6'b000100, 4'h0, 8'h00, 3'd0, 3'd0, 3'd0, 2'b00, 4'h0, 8'hE0, 16'd12);
        // Reset lands in the literal cycle: everything zero, long jump dropped.
        step("rstLit", 1'b1, 8'h77, 6'b000000, 4'h0, 8'h00, 3'd0, 3'd0, 3'd0, 2'b00, 4'h0, 8'h00, 16'd0);
        step("postRst", 1'b0, 8'h35, 6'b100000, 4'h0, 8'h00, 3'd3, 3'd0, 3'd0, 2'b00, 4'h5, 8'h35, 16'd1);
        step("movBF", 1'b0, 8'hBF, 6'b010000, 4'h0, 8'h00, 3'd7, 3'd7, 3'd0, 2'b00, 4'h0, 8'hBF, 16'd2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
